// File: rtl/alu128_pkg.sv
// Shared types and constants for the 128-bit ALU
// op sequencer, the ALU top and the bench.
package alu128_pkg;

  localparam int WIDTH   = 128;
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_RESP
  } state_e;

  function automatic logic is_legal_op(
    input logic [2:0] op
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu128_op_sequencer_if.sv
// Request, ALU-drive and response bundle of the
// sequencer; slave = sequencer, master = its peers.
interface alu128_op_sequencer_if;
  import alu128_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [2:0]         req_op;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic [SHAMT_W-1:0] req_shamt;
  logic               req_fill;

  logic [2:0]         alu_opsel;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_cin;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_cout;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_cout;
  logic               rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  req_shamt, req_fill,
    output req_ready,
    output alu_opsel, alu_a, alu_b, alu_cin,
    input  alu_result, alu_cout,
    output rsp_valid, rsp_result, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output req_shamt, req_fill,
    input  req_ready,
    input  alu_opsel, alu_a, alu_b, alu_cin,
    output alu_result, alu_cout,
    input  rsp_valid, rsp_result, rsp_cout, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu128_shift_counter.sv
// Remaining-steps counter for iterated 1-bit shifts;
// last flags the final step of a shift sequence.
module alu128_shift_counter
  import alu128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [SHAMT_W-1:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [SHAMT_W-1:0] count_q;
  logic [SHAMT_W-1:0] count_d;

  // next count: load wins, decrement saturates at 0
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign last = (count_q == SHAMT_W'(1));

endmodule

// File: rtl/alu128_op_sequencer.sv
// Drives the bit-sliced ALU one request at a time,
// iterating its 1-bit shift for multi-bit shifts.
module alu128_op_sequencer
  import alu128_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  alu128_op_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_err_q, rsp_err_d;
  logic [2:0]       alu_opsel_q, alu_opsel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             cnt_load, cnt_dec, cnt_last;
  logic             accept;

  alu128_shift_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (bus.req_shamt),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign accept = bus.req_valid & req_ready_q;

  // FSM next state; alu_a doubles as the shift
  // working register, ALU is idled outside EXEC/SHIFT
  always_comb begin
    state_d      = state_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;
    alu_opsel_d  = alu_opsel_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_result_d = '0;
          rsp_cout_d   = 1'b0;
          rsp_err_d    = 1'b0;
          if (!is_legal_op(bus.req_op)) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else if (bus.req_op == OP_SHL) begin
            if (bus.req_shamt == '0) begin
              state_d      = ST_RESP;
              rsp_result_d = bus.req_a;
            end else begin
              state_d     = ST_SHIFT;
              cnt_load    = 1'b1;
              alu_opsel_d = OP_SHL;
              alu_a_d     = bus.req_a;
              alu_cin_d   = bus.req_fill;
            end
          end else begin
            state_d     = ST_EXEC;
            alu_opsel_d = bus.req_op;
            alu_a_d     = bus.req_a;
            alu_b_d     = bus.req_b;
          end
        end
      end
      ST_EXEC: begin
        state_d      = ST_RESP;
        rsp_result_d = bus.alu_result;
        alu_opsel_d  = OP_AND;
        alu_a_d      = '0;
        alu_b_d      = '0;
        alu_cin_d    = 1'b0;
      end
      ST_SHIFT: begin
        cnt_dec    = 1'b1;
        rsp_cout_d = bus.alu_cout;
        alu_a_d    = bus.alu_result;
        if (cnt_last) begin
          state_d      = ST_RESP;
          rsp_result_d = bus.alu_result;
          alu_opsel_d  = OP_AND;
          alu_a_d      = '0;
          alu_cin_d    = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_opsel_q  <= OP_AND;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
      alu_opsel_q  <= alu_opsel_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_opsel  = alu_opsel_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = alu_cin_q;

endmodule

// File: tb/tb_alu128_op_sequencer.sv
// Bench for alu128_op_sequencer: behavioural ALU,
// directed table, corner sequences, random vs model.
module tb_alu128_op_sequencer;
  import alu128_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu128_op_sequencer_if bus ();

  alu128_op_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural bit-sliced ALU
  always_comb begin
    bus.alu_result = '0;
    bus.alu_cout   = 1'b0;
    case (bus.alu_opsel)
      3'b000: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b010: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b011: bus.alu_result = ~bus.alu_a;
      3'b101: begin
        bus.alu_result = {bus.alu_a[WIDTH-2:0], bus.alu_cin};
        bus.alu_cout   = bus.alu_a[WIDTH-1];
      end
      default: ;
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;
  int shift_cyc = 0;
  int bad_opsel = 0;

  always @(negedge clk) begin
    if (bus.alu_opsel == 3'b101) shift_cyc++;
    if (bus.alu_opsel == 3'b100 ||
        bus.alu_opsel == 3'b110 ||
        bus.alu_opsel == 3'b111) bad_opsel++;
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: plain arithmetic from the op rules
  task automatic model(input logic [2:0] op,
                       input logic [127:0] a,
                       input logic [127:0] b,
                       input logic [6:0] shamt,
                       input logic fill,
                       output logic [127:0] res,
                       output logic cout,
                       output logic err,
                       output int lat,
                       output int scyc);
    logic [127:0] one;
    int n;
    one = 128'd1;
    n = int'(shamt);
    res = '0; cout = 0; err = 0; lat = 2; scyc = 0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: res = a ^ b;
      3'b011: res = ~a;
      3'b101: begin
        res = a << n;
        if (fill) res = res | ((one << n) - one);
        cout = (n == 0) ? 1'b0 : a[128 - n];
        lat  = n + 1;
        scyc = n;
      end
      default: begin
        err = 1;
        lat = 1;
      end
    endcase
  endtask

  task automatic run_txn(input logic [2:0] op,
                         input logic [127:0] a,
                         input logic [127:0] b,
                         input logic [6:0] shamt,
                         input logic fill,
                         input int hold,
                         output logic [127:0] res,
                         output logic cout,
                         output logic err,
                         output int lat,
                         output int scyc);
    int w;
    bit ok;
    w = 0;
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) chk("req_ready_wait", 0, 1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_shamt = shamt;
    bus.req_fill  = fill;
    shift_cyc = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = rnd128();
    bus.req_b     = rnd128();
    bus.req_op    = 3'($urandom);
    bus.req_shamt = 7'($urandom);
    bus.req_fill  = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
    res  = bus.rsp_result;
    cout = bus.rsp_cout;
    err  = bus.rsp_err;
    scyc = shift_cyc;
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'($urandom);
      bus.req_op    = 3'($urandom);
      bus.req_a     = rnd128();
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 ||
          bus.rsp_result !== res ||
          bus.rsp_cout !== cout ||
          bus.rsp_err !== err ||
          bus.req_ready !== 1'b0) ok = 0;
    end
    bus.req_valid = 1'b0;
    if (hold > 0) chk("backpressure_stable", 128'(ok), 1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp",
        {bus.req_ready, bus.rsp_valid}, 2'b10);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [6:0]   shamt;
    logic         fill;
    logic [127:0] exp_res;
    logic         exp_cout;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready_valid"},
        {bus.req_ready, bus.rsp_valid}, 2'b10);
    chk({nm, "_rsp"},
        {bus.rsp_result, bus.rsp_cout, bus.rsp_err}, 0);
    chk({nm, "_alu"},
        {bus.alu_opsel, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
  endtask

  initial begin
    logic [127:0] r, er;
    logic c, e, ec, ee;
    int lat, sc, el, es, w;
    bit seen;
    logic [2:0] op;
    logic [6:0] sh;

    tbl[0]  = '{3'b000, {8{16'hFF00}}, {8{16'h0FF0}}, 7'd0, 1'b0,
                {8{16'h0F00}}, 1'b0, 1'b0, 2};
    tbl[1]  = '{3'b001, {16{8'hF0}}, {16{8'h0F}}, 7'd3, 1'b1,
                {128{1'b1}}, 1'b0, 1'b0, 2};
    tbl[2]  = '{3'b010, {4{32'hDEADBEEF}}, {4{32'hFFFFFFFF}}, 7'd0,
                1'b0, {4{32'h21524110}}, 1'b0, 1'b0, 2};
    tbl[3]  = '{3'b011, {2{64'h0123456789ABCDEF}}, 128'd7, 7'd0,
                1'b0, {2{64'hFEDCBA9876543210}}, 1'b0, 1'b0, 2};
    tbl[4]  = '{3'b101, 128'd1, 128'd0, 7'd5, 1'b0,
                128'h20, 1'b0, 1'b0, 6};
    tbl[5]  = '{3'b101, {1'b1, 127'd0}, 128'd0, 7'd1, 1'b1,
                128'd1, 1'b1, 1'b0, 2};
    tbl[6]  = '{3'b101, {4{32'h12345678}}, 128'd0, 7'd0, 1'b1,
                {4{32'h12345678}}, 1'b0, 1'b0, 1};
    tbl[7]  = '{3'b110, 128'd1, 128'd1, 7'd4, 1'b0,
                128'd0, 1'b0, 1'b1, 1};
    tbl[8]  = '{3'b100, {128{1'b1}}, 128'd1, 7'd4, 1'b0,
                128'd0, 1'b0, 1'b1, 1};
    tbl[9]  = '{3'b111, {128{1'b1}}, 128'd1, 7'd0, 1'b1,
                128'd0, 1'b0, 1'b1, 1};
    tbl[10] = '{3'b101, {128{1'b1}}, 128'd0, 7'd127, 1'b0,
                {1'b1, 127'd0}, 1'b1, 1'b0, 128};
    tbl[11] = '{3'b101, 128'd0, 128'd0, 7'd127, 1'b1,
                {1'b0, {127{1'b1}}}, 1'b0, 1'b0, 128};

    bus.req_valid = 0; bus.req_op = 0;
    bus.req_a = 0; bus.req_b = 0;
    bus.req_shamt = 0; bus.req_fill = 0;
    bus.rsp_ready = 0;

    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].shamt, tbl[i].fill, 0,
              r, c, e, lat, sc);
      es = (tbl[i].op == 3'b101) ? int'(tbl[i].shamt) : 0;
      chk($sformatf("vec%0d_result", i), r, tbl[i].exp_res);
      chk($sformatf("vec%0d_cout", i), c, tbl[i].exp_cout);
      chk($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_shift_cycles", i), sc, es);
    end

    // backpressure: 10 cycles of rsp_ready low
    run_txn(3'b010, {4{32'hA5A5A5A5}}, {4{32'h0000FFFF}},
            7'd0, 1'b0, 10, r, c, e, lat, sc);
    chk("bp_result", r, {4{32'hA5A55A5A}});
    run_txn(3'b101, 128'h3, 128'd0, 7'd2, 1'b1, 10,
            r, c, e, lat, sc);
    chk("bp_next_result", r, 128'hF);

    // reset in the middle of a 100-step shift
    bus.req_valid = 1; bus.req_op = 3'b101;
    bus.req_a = rnd128(); bus.req_shamt = 7'd100;
    bus.req_fill = 1;
    shift_cyc = 0;
    @(posedge clk);
    #1 bus.req_valid = 0;
    w = 0;
    @(negedge clk);
    while (shift_cyc < 40 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("midshift_reached", shift_cyc, 40);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("midshift_rst");
    rst = 0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("midshift_no_rsp", 128'(seen), 0);
    run_txn(3'b101, 128'h1, 128'd0, 7'd3, 1'b0, 0,
            r, c, e, lat, sc);
    chk("post_rst_result", r, 128'h8);
    chk("post_rst_shift_cycles", sc, 3);

    // random regression against the reference model
    for (int i = 0; i < 1000; i++) begin
      op = 3'($urandom_range(0, 7));
      sh = ($urandom_range(0, 3) == 0) ? 7'd0
                                      : 7'($urandom_range(1, 127));
      if ($urandom_range(0, 1) == 1) sh = 7'($urandom_range(0, 8));
      er = rnd128();
      model(op, er, ~er ^ rnd128(), sh, 1'($urandom),
            er, ec, ee, el, es);
      // model reused er as output; rebuild inputs deterministically
      er = 0;
      begin
        logic [127:0] a, b, mr;
        logic f, mc, me;
        int ml, ms, hold;
        a = rnd128(); b = rnd128(); f = 1'($urandom);
        hold = $urandom_range(0, 3);
        model(op, a, b, sh, f, mr, mc, me, ml, ms);
        run_txn(op, a, b, sh, f, hold, r, c, e, lat, sc);
        chk($sformatf("rnd%0d_result", i), r, mr);
        chk($sformatf("rnd%0d_cout", i), c, mc);
        chk($sformatf("rnd%0d_err", i), e, me);
        chk($sformatf("rnd%0d_latency", i), lat, ml);
        chk($sformatf("rnd%0d_shift_cycles", i), sc, ms);
      end
    end

    chk("no_illegal_opsel", bad_opsel, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
